// File: rtl/msg_framer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msg_framer_if                                                |
// | Description : Message-in / AXI-Stream-out bundle for msg_framer.           |
// |               master = framer side, slave = message source / stream sink.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface msg_framer_if #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int DATA_BYTES    = 8
);
  logic                       msg_valid;
  logic                       msg_ready;
  logic [15:0]                msg_length;
  logic [8*MAX_MSG_BYTES-1:0] msg_data;
  logic                       msg_error;

  logic                       m_tvalid;
  logic                       m_tready;
  logic [8*DATA_BYTES-1:0]    m_tdata;
  logic [DATA_BYTES-1:0]      m_tkeep;
  logic                       m_tlast;
  logic                       m_tuser;

  modport master (
    input  msg_valid, msg_length, msg_data, msg_error, m_tready,
    output msg_ready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser
  );

  modport slave (
    output msg_valid, msg_length, msg_data, msg_error, m_tready,
    input  msg_ready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser
  );
endinterface
`default_nettype wire

// File: rtl/msg_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msg_framer                                                   |
// | Description : Serializes one buffered parallel message (LSB-first) into    |
// |               DATA_BYTES-wide AXI-Stream beats with tkeep/tlast/tuser.     |
// |               Interface parameters must match the module parameters.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module msg_framer #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int DATA_BYTES    = 8
) (
  input  logic         clk,
  input  logic         rst,
  msg_framer_if.master bus
);
  localparam int          c_BEATS   = MAX_MSG_BYTES / DATA_BYTES;
  localparam int          c_CNT_W   = $clog2(c_BEATS) + 1;
  localparam int          c_BUF_W   = 8 * MAX_MSG_BYTES;
  localparam int          c_BEAT_W  = 8 * DATA_BYTES;
  localparam logic [15:0] c_MAX_LEN = 16'(MAX_MSG_BYTES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]            r_state;
  logic [c_BUF_W-1:0]    r_buf;
  logic [15:0]           r_len;
  logic [c_CNT_W-1:0]    r_nbeats;
  logic [c_CNT_W-1:0]    r_beat;
  logic                  r_err;
  logic                  r_msg_ready;
  logic                  r_tvalid;
  logic [c_BEAT_W-1:0]   r_tdata;
  logic [DATA_BYTES-1:0] r_tkeep;
  logic                  r_tlast;
  logic                  r_tuser;

  logic                  w_accept;
  logic [15:0]           w_acc_len;
  logic                  w_acc_err;
  logic [c_CNT_W-1:0]    w_acc_nbeats;

  logic [c_BUF_W-1:0]    w_src_data;
  logic [15:0]           w_src_len;
  logic [c_CNT_W-1:0]    w_src_nbeats;
  logic                  w_src_err;
  logic [c_CNT_W-1:0]    w_idx;
  logic [c_CNT_W-1:0]    w_word_idx;
  logic [c_BEAT_W-1:0]   w_word;
  logic [31:0]           w_base;
  logic [c_BEAT_W-1:0]   w_data;
  logic [DATA_BYTES-1:0] w_keep;
  logic                  w_last;
  logic                  w_user;

  // Message acceptance and its derived length / error / beat count.
  assign w_accept     = (r_state == S_IDLE) && r_msg_ready && bus.msg_valid;
  assign w_acc_len    = (bus.msg_length > c_MAX_LEN) ? c_MAX_LEN : bus.msg_length;
  assign w_acc_err    = bus.msg_error || (bus.msg_length > c_MAX_LEN) || (bus.msg_length == 16'd0);
  assign w_acc_nbeats = (w_acc_len == 16'd0) ? c_CNT_W'(1)
                      : c_CNT_W'((w_acc_len + 16'(DATA_BYTES - 1)) / 16'(DATA_BYTES));

  // Source of the next beat to register: the incoming message on accept,
  // otherwise the buffered message at the following beat index.
  always_comb begin
    w_src_data   = r_buf;
    w_src_len    = r_len;
    w_src_nbeats = r_nbeats;
    w_src_err    = r_err;
    w_idx        = r_beat + c_CNT_W'(1);
    if (r_state == S_IDLE) begin
      w_src_data   = bus.msg_data;
      w_src_len    = w_acc_len;
      w_src_nbeats = w_acc_nbeats;
      w_src_err    = w_acc_err;
      w_idx        = '0;
    end
  end

  // Past-the-end index only occurs when no further beat will be loaded.
  assign w_word_idx = (w_idx < c_CNT_W'(c_BEATS)) ? w_idx : '0;
  assign w_word     = w_src_data[c_BEAT_W*w_word_idx +: c_BEAT_W];
  assign w_base     = 32'(w_idx) * 32'(DATA_BYTES);

  // A lane is kept only while its absolute byte position is below the length;
  // dropped lanes are forced to zero.
  for (genvar j = 0; j < DATA_BYTES; j++) begin : g_lane
    assign w_keep[j]         = (w_base + 32'(j)) < 32'(w_src_len);
    assign w_data[8*j +: 8]  = w_keep[j] ? w_word[8*j +: 8] : 8'h00;
  end

  assign w_last = (w_idx == (w_src_nbeats - c_CNT_W'(1)));
  assign w_user = w_last && w_src_err;

  // Framing FSM: latch a message in IDLE, then present beats until tlast handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_len       <= '0;
      r_nbeats    <= '0;
      r_beat      <= '0;
      r_err       <= 1'b0;
      r_msg_ready <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_msg_ready <= 1'b1;
          if (w_accept) begin
            r_buf       <= bus.msg_data;
            r_len       <= w_acc_len;
            r_nbeats    <= w_acc_nbeats;
            r_err       <= w_acc_err;
            r_beat      <= '0;
            r_msg_ready <= 1'b0;
            r_state     <= S_SEND;
            r_tvalid    <= 1'b1;
            r_tdata     <= w_data;
            r_tkeep     <= w_keep;
            r_tlast     <= w_last;
            r_tuser     <= w_user;
          end
        end
        S_SEND: begin
          if (bus.m_tready) begin
            if (r_tlast) begin
              r_state     <= S_IDLE;
              r_msg_ready <= 1'b1;
              r_tvalid    <= 1'b0;
              r_tdata     <= '0;
              r_tkeep     <= '0;
              r_tlast     <= 1'b0;
              r_tuser     <= 1'b0;
            end else begin
              r_beat  <= w_idx;
              r_tdata <= w_data;
              r_tkeep <= w_keep;
              r_tlast <= w_last;
              r_tuser <= w_user;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.msg_ready = r_msg_ready;
  assign bus.m_tvalid  = r_tvalid;
  assign bus.m_tdata   = r_tdata;
  assign bus.m_tkeep   = r_tkeep;
  assign bus.m_tlast   = r_tlast;
  assign bus.m_tuser   = r_tuser;
endmodule
`default_nettype wire

// File: tb/tb_msg_framer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_msg_framer                                                |
// | Description : Self-checking bench for msg_framer against a byte-queue      |
// |               reference model, directed and random messages.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_msg_framer;
  localparam int MAXB = 32;
  localparam int DB   = 8;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  msg_framer_if #(.MAX_MSG_BYTES(MAXB), .DATA_BYTES(DB)) bus ();

  msg_framer #(.MAX_MSG_BYTES(MAXB), .DATA_BYTES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t        exp_q[$];
  bit           rdy_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           nxt_len;
  bit           nxt_err;
  logic [255:0] nxt_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: keep the first min(len,MAX) bytes, chop into groups of DB.
  function automatic void build_model(input int len, input bit err, input logic [255:0] data);
    logic [7:0] bytes[$];
    beat_t      bt;
    int         eff;
    bit         e;
    exp_q.delete();
    eff = (len > MAXB) ? MAXB : len;
    e   = err || (len > MAXB) || (len == 0);
    for (int i = 0; i < eff; i++) bytes.push_back(data[i*8 +: 8]);
    if (eff == 0) begin
      bt = '0; bt.l = 1'b1; bt.u = e;
      exp_q.push_back(bt);
    end
    while (bytes.size() > 0) begin
      bt = '0;
      for (int j = 0; j < DB && bytes.size() > 0; j++) begin
        bt.d[j*8 +: 8] = bytes.pop_front();
        bt.k[j]        = 1'b1;
      end
      bt.l = (bytes.size() == 0);
      bt.u = bt.l && e;
      exp_q.push_back(bt);
    end
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the last beat handshake.
  // mode: 0 tready high, 1 tready from rdy_q then high, 2 random tready.
  task automatic run_msg(input int len, input bit err, input logic [255:0] data,
                         input int mode, input bit hold);
    int wait_c;
    int cyc;
    int k;
    bit rdy;
    build_model(len, err, data);
    bus.msg_length = 16'(len);
    bus.msg_error  = err;
    bus.msg_data   = data;
    bus.msg_valid  = 1'b1;
    wait_c = 0;
    while (bus.msg_ready !== 1'b1 && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    if (bus.msg_ready !== 1'b1) begin
      n_vec++; n_err++;
      $error("FAIL accept_timeout observed=%b expected=1", bus.msg_ready);
      bus.msg_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (hold) begin
      bus.msg_length = 16'(nxt_len);
      bus.msg_error  = nxt_err;
      bus.msg_data   = nxt_data;
    end else begin
      bus.msg_valid = 1'b0;
    end
    k = 0;
    cyc = 0;
    while (k < exp_q.size() && cyc < 200) begin
      check("tvalid", 64'(bus.m_tvalid), 64'(1));
      check("msg_ready_busy", 64'(bus.msg_ready), 64'(0));
      check("tdata", bus.m_tdata, exp_q[k].d);
      check("tkeep", 64'(bus.m_tkeep), 64'(exp_q[k].k));
      check("tlast", 64'(bus.m_tlast), 64'(exp_q[k].l));
      check("tuser", 64'(bus.m_tuser), 64'(exp_q[k].u));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.m_tready = rdy;
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    if (k < exp_q.size()) begin
      n_vec++; n_err++;
      $error("FAIL beat_timeout observed=%0d expected=%0d", k, exp_q.size());
    end
    if (mode == 0) check("consecutive_beats", 64'(cyc), 64'(exp_q.size()));
    bus.m_tready = 1'b0;
    check("tvalid_idle", 64'(bus.m_tvalid), 64'(0));
    check("msg_ready_back", 64'(bus.msg_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] d;
    int           wait_c;
    bus.msg_valid  = 1'b0;
    bus.msg_length = '0;
    bus.msg_data   = '0;
    bus.msg_error  = 1'b0;
    bus.m_tready   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_msg_ready", 64'(bus.msg_ready), 64'(0));
    check("rst_tvalid", 64'(bus.m_tvalid), 64'(0));
    check("rst_tdata", bus.m_tdata, 64'(0));
    check("rst_tkeep", 64'(bus.m_tkeep), 64'(0));
    check("rst_tlast", 64'(bus.m_tlast), 64'(0));
    check("rst_tuser", 64'(bus.m_tuser), 64'(0));
    rst = 1'b1;
    #1 check("ready_before_edge", 64'(bus.msg_ready), 64'(0));
    @(negedge clk);
    check("ready_after_edge", 64'(bus.msg_ready), 64'(1));

    // len=20, continuous tready
    run_msg(20, 1'b0, rand_data(), 0, 1'b0);
    // len=8 flagged bad
    run_msg(8, 1'b1, rand_data(), 0, 1'b0);
    // len=32 with stall pattern
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run_msg(32, 1'b0, rand_data(), 1, 1'b0);
    // oversize, then empty
    run_msg(40, 1'b0, rand_data(), 0, 1'b0);
    run_msg(0, 1'b0, rand_data(), 0, 1'b0);
    // back-to-back with msg_valid held through SEND
    nxt_len  = 3;
    nxt_err  = 1'b0;
    nxt_data = rand_data();
    run_msg(9, 1'b0, rand_data(), 0, 1'b1);
    run_msg(nxt_len, nxt_err, nxt_data, 0, 1'b0);

    // random messages under random backpressure
    for (int m = 0; m < 20; m++) begin
      run_msg($urandom_range(0, 45), 1'($urandom_range(0, 1)), rand_data(), 2, 1'b0);
    end

    // asynchronous reset during beat 2 of a len=24 message
    d = rand_data();
    bus.msg_length = 16'd24;
    bus.msg_error  = 1'b0;
    bus.msg_data   = d;
    bus.msg_valid  = 1'b1;
    wait_c = 0;
    while (bus.msg_ready !== 1'b1 && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    check("mid_rst_ready", 64'(bus.msg_ready), 64'(1));
    @(negedge clk);
    bus.msg_valid = 1'b0;
    bus.m_tready  = 1'b1;
    @(negedge clk);
    check("mid_rst_beat2_valid", 64'(bus.m_tvalid), 64'(1));
    check("mid_rst_beat2_data", bus.m_tdata, d[127:64]);
    #2 rst = 1'b0;
    #1;
    check("async_tvalid", 64'(bus.m_tvalid), 64'(0));
    check("async_tdata", bus.m_tdata, 64'(0));
    check("async_tkeep", 64'(bus.m_tkeep), 64'(0));
    check("async_tlast", 64'(bus.m_tlast), 64'(0));
    check("async_msg_ready", 64'(bus.msg_ready), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.msg_ready), 64'(1));
    check("post_rst_tvalid", 64'(bus.m_tvalid), 64'(0));
    repeat (4) begin
      @(negedge clk);
      check("no_residual_beat", 64'(bus.m_tvalid), 64'(0));
    end
    bus.m_tready = 1'b0;
    run_msg(5, 1'b0, rand_data(), 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
